psg_bus_if: RTL

Host-bus front end of the PSG core. It samples the asynchronous 8-bit write bus (pD[7:0], WEb, CEb) into the `clk` domain and detects each write strobe once. Each written byte is buffered in a small FIFO and presented to the register-decode stage (`reception`) as a valid/ready stream. The block also produces the SN76489-style READY output that throttles the host after every write.

---
 rtl/psg_pkg.sv | 14 +
 rtl/psg_sync_fifo.sv | 76 +++++++
 rtl/psg_bus_if.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// psg_pkg: shared definitions for the PSG core.
//   PSG_DATA_W    - width of a host-bus byte
//   ready_state_e - state of the host READY throttle (IDLE, BUSY)
// Also imported by the register-decode stage and control_reg.
package psg_pkg;

  localparam int unsigned PSG_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ready_state_e;

endpackage

// File: rtl/psg_sync_fifo.sv
// psg_sync_fifo: single-clock circular-buffer FIFO.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   push       - write push_data this cycle (ignored when full unless pop also occurs)
//   push_data  - byte to store
//   pop        - remove the head entry this cycle (ignored when empty)
//   full       - level == DEPTH
//   empty      - level == 0
//   level      - current occupancy
//   head_data  - entry at the read pointer, combinational from storage
module psg_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [WIDTH-1:0]           head_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign level     = level_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/psg_bus_if.sv
// psg_bus_if: host-bus front end of the PSG core.
// Samples the asynchronous write bus into clk, detects one write per WEb low period,
// buffers the bytes in a FIFO and throttles the host with an SN76489-style READY.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   pD         - host data bus (asynchronous)
//   WEb, CEb   - host write / chip enable, active low (asynchronous)
//   ready      - 1 = host may write, 0 = busy (registered)
//   out_data   - byte at FIFO head
//   out_valid  - FIFO non-empty
//   out_ready  - consumer accepts out_data when out_valid is 1
//   overflow   - sticky, a write was dropped on a full FIFO
//   level      - FIFO occupancy
module psg_bus_if
  import psg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READY_CYCLES = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PSG_DATA_W-1:0]           pD,
  input  logic                            WEb,
  input  logic                            CEb,
  output logic                            ready,
  output logic [PSG_DATA_W-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;

  // Synchroniser: two flops per bus line, a third on act for edge detection.
  logic                  act_s1_q, act_s2_q, act_s3_q;
  logic [PSG_DATA_W-1:0] data_s1_q, data_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_s1_q  <= 1'b0;
      act_s2_q  <= 1'b0;
      act_s3_q  <= 1'b0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      act_s1_q  <= ~WEb & ~CEb;
      act_s2_q  <= act_s1_q;
      act_s3_q  <= act_s2_q;
      data_s1_q <= pD;
      data_s2_q <= data_s1_q;
    end
  end

  logic          push_req, push_acc, pop;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level, level_d;

  // Rising edge of the synchronised strobe: one request per host write.
  assign push_req = act_s2_q & ~act_s3_q;
  assign pop      = ~fifo_empty & out_ready;
  assign push_acc = push_req & (~fifo_full | pop);

  psg_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PSG_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_acc),
    .push_data (data_s2_q),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head_data (out_data)
  );

  // Occupancy after this edge, so the registered ready reflects the same edge's push/pop.
  always_comb begin
    level_d = fifo_level;
    unique case ({push_acc, pop})
      2'b10:   level_d = fifo_level + LW'(1);
      2'b01:   level_d = fifo_level - LW'(1);
      default: level_d = fifo_level;
    endcase
  end

  // READY throttle.
  ready_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          overflow_q, overflow_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (push_acc) begin
          state_d = BUSY;
          cnt_d   = CW'(READY_CYCLES - 1);
        end
      end
      BUSY: begin
        // A new write restarts the full hold-off window.
        if (push_acc) begin
          cnt_d = CW'(READY_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  assign ready_d    = (state_d == IDLE) & (level_d < LW'(FIFO_DEPTH));
  assign overflow_d = overflow_q | (push_req & ~push_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready     = ready_q;
  assign overflow  = overflow_q;
  assign out_valid = ~fifo_empty;
  assign level     = fifo_level;

endmodule
